// File: rtl/writeback_register_file.sv
// Write-back stage and 32 x 32-bit architectural register file for the MIPS pipeline.
// Define WB_REGFILE_BYPASS_EN to forward the committing value to a matching read port in the same cycle.
module writeback_register_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        memToRegInput,
  input  logic        regWriteInput,
  input  logic [31:0] dataMemoryInput,
  input  logic [31:0] aluResultInput,
  input  logic [4:0]  regWriteAddressInput,
  input  logic [4:0]  readAddressAInput,
  input  logic [4:0]  readAddressBInput,
  output logic [31:0] readDataAOutput,
  output logic [31:0] readDataBOutput,
  output logic [31:0] writeDataOutput,
  output logic [31:0] writeCountOutput
);

  // r0 is hardwired to zero, so only r1..r31 have storage.
  logic [31:0] regs [1:31];
  logic [31:0] write_count;
  logic [31:0] write_data;
  logic        commit;

  assign write_data       = memToRegInput ? dataMemoryInput : aluResultInput;
  assign writeDataOutput  = write_data;
  assign writeCountOutput = write_count;

  // Reset is folded into the commit term so the bypass never forwards a dropped write.
  assign commit = reset && regWriteInput && (regWriteAddressInput != 5'd0);

  // NOTE: the storage array is explicitly cleared on reset because software
  // observes every register reading 0 afterwards; most RAM-style arrays are
  // left unreset, but this one is small flops, not a macro.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        // NOTE: non-blocking assignments in clocked logic so every flop
        // samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
      write_count <= '0;
    end else if (commit) begin
      regs[regWriteAddressInput] <= write_data;
      write_count                <= write_count + 32'd1;
    end
  end

  function automatic logic [31:0] stored_value(input logic [4:0] addr);
    stored_value = (addr == 5'd0) ? 32'd0 : regs[addr];
  endfunction

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    readDataAOutput = stored_value(readAddressAInput);
    readDataBOutput = stored_value(readAddressBInput);
`ifdef WB_REGFILE_BYPASS_EN
    if (commit && (readAddressAInput == regWriteAddressInput)) readDataAOutput = write_data;
    if (commit && (readAddressBInput == regWriteAddressInput)) readDataBOutput = write_data;
`else
    // Without bypass, decode sees the old value; the hazard unit covers the gap.
`endif
  end

endmodule

// File: tb/tb_writeback_register_file.sv
// Self-checking bench for writeback_register_file: vector table plus hand-written
// sequences for same-cycle read, stall/flush and reset-versus-write.
module tb_writeback_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        memToRegInput;
  logic        regWriteInput;
  logic [31:0] dataMemoryInput;
  logic [31:0] aluResultInput;
  logic [4:0]  regWriteAddressInput;
  logic [4:0]  readAddressAInput;
  logic [4:0]  readAddressBInput;
  logic [31:0] readDataAOutput;
  logic [31:0] readDataBOutput;
  logic [31:0] writeDataOutput;
  logic [31:0] writeCountOutput;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_register_file dut (
    .clk                  (clk),
    .reset                (reset),
    .memToRegInput        (memToRegInput),
    .regWriteInput        (regWriteInput),
    .dataMemoryInput      (dataMemoryInput),
    .aluResultInput       (aluResultInput),
    .regWriteAddressInput (regWriteAddressInput),
    .readAddressAInput    (readAddressAInput),
    .readAddressBInput    (readAddressBInput),
    .readDataAOutput      (readDataAOutput),
    .readDataBOutput      (readDataBOutput),
    .writeDataOutput      (writeDataOutput),
    .writeCountOutput     (writeCountOutput)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        m2r;
    logic        rw;
    logic [31:0] dm;
    logic [31:0] alu;
    logic [4:0]  wa;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_wd;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic rst, input logic m2r, input logic rw, input logic [31:0] dm,
                       input logic [31:0] alu, input logic [4:0] wa, input logic [4:0] ra,
                       input logic [4:0] rb);
    reset = rst; memToRegInput = m2r; regWriteInput = rw; dataMemoryInput = dm;
    aluResultInput = alu; regWriteAddressInput = wa; readAddressAInput = ra; readAddressBInput = rb;
  endtask

  // Idle inputs and read two registers back; nothing commits.
  task automatic read_back(input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, ra, rb);
    #1;
  endtask

  initial begin
    vecs[0] = '{"reset0",     1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd5, 5'd5, 32'h0,        32'h0,        32'h0,        32'd0};
    vecs[1] = '{"preload_r5", 1'b1, 1'b0, 1'b1, 32'h0,        32'h1234,     5'd5, 5'd5, 5'd5, 32'h1234,     32'h1234,     32'h1234,     32'd1};
    vecs[2] = '{"reset_r5",   1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd5, 5'd5, 32'h0,        32'h0,        32'h0,        32'd0};
    vecs[3] = '{"alu_wb_r7",  1'b1, 1'b0, 1'b1, 32'h77,       32'hDEADBEEF, 5'd7, 5'd7, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'd1};
    vecs[4] = '{"load_r3",    1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 32'h1,        5'd3, 5'd3, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hDEADBEEF, 32'd2};
    vecs[5] = '{"r0_guard",   1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 32'h1,        5'd0, 5'd0, 5'd0, 32'hCAFEF00D, 32'h0,        32'h0,        32'd2};
    vecs[6] = '{"no_regwr",   1'b1, 1'b0, 1'b0, 32'h5,        32'h99,       5'd3, 5'd3, 5'd7, 32'h99,       32'hCAFEF00D, 32'hDEADBEEF, 32'd2};
    vecs[7] = '{"r9_old",     1'b1, 1'b0, 1'b1, 32'h0,        32'h11,       5'd9, 5'd9, 5'd3, 32'h11,       32'h11,       32'hCAFEF00D, 32'd3};

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].m2r, vecs[i].rw, vecs[i].dm, vecs[i].alu, vecs[i].wa,
            vecs[i].ra, vecs[i].rb);
      #1;
      check({vecs[i].name, "_wd"}, writeDataOutput, vecs[i].exp_wd);
      @(posedge clk);
      #1;
      read_back(vecs[i].ra, vecs[i].rb);
      check({vecs[i].name, "_a"}, readDataAOutput, vecs[i].exp_a);
      check({vecs[i].name, "_b"}, readDataBOutput, vecs[i].exp_b);
      check({vecs[i].name, "_cnt"}, writeCountOutput, vecs[i].exp_cnt);
    end

    // Same-cycle read of the register being written (r9 holds 0x11).
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h55, 5'd9, 5'd3, 5'd9);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("same_cycle_b", readDataBOutput, 32'h55);
`else
    check("same_cycle_b", readDataBOutput, 32'h11);
`endif
    check("same_cycle_a", readDataAOutput, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    read_back(5'd9, 5'd9);
    check("next_cycle_b", readDataBOutput, 32'h55);
    check("next_cycle_cnt", writeCountOutput, 32'd4);

    // Stall: same write held for three edges, each counted.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h10, 5'd4, 5'd4, 5'd9);
    repeat (3) @(posedge clk);
    #1;
    read_back(5'd4, 5'd9);
    check("stall_r4", readDataAOutput, 32'h10);
    check("stall_r9_cleared", readDataBOutput, 32'h0);
    check("stall_cnt", writeCountOutput, 32'd3);

    // Flush: regWrite low for two edges.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'hBAD, 5'd4, 5'd4, 5'd4);
    repeat (2) @(posedge clk);
    #1;
    check("flush_r4", readDataAOutput, 32'h10);
    check("flush_cnt", writeCountOutput, 32'd3);

    // Reset in the same cycle as a write: the write is dropped.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hAB, 5'd2, 5'd2, 5'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'hFF, 5'd2, 5'd2, 5'd4);
    #1;
    check("rst_write_no_bypass", readDataAOutput, 32'hAB);
    @(posedge clk);
    #1;
    read_back(5'd2, 5'd4);
    check("rst_write_r2", readDataAOutput, 32'h0);
    check("rst_write_r4", readDataBOutput, 32'h0);
    check("rst_write_cnt", writeCountOutput, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
